// File: rtl/score_digit_scanner.sv
// Score-to-BCD converter and four-digit display scanner for the Snake game.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros in score mode.
module score_digit_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [13:0] i_Score,
    input  logic [1:0]  i_Mode,
    output logic [7:0]  o_Digit,
    output logic [3:0]  o_Anode,
    output logic        o_Busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [13:0]      MAX_SCORE = 14'd9999;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]  idx_q;
    logic [13:0] lat_q, lat_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] bcd_q, bcd_d;
    logic [13:0] bin_q, bin_d;
    logic [3:0]  iter_q, iter_d;
    logic [7:0]  digit_q;
    logic [3:0]  anode_q;

    logic        tick;
    logic        score_ok;
    logic [1:0]  idx_nxt;
    logic [3:0]  nib;
    logic [7:0]  digit_nxt;
    logic [3:0]  anode_nxt;
    logic [15:0] bcd_adj;

    assign tick     = (cnt_q == DIV_LAST);
    assign score_ok = (i_Score <= MAX_SCORE);
    assign idx_nxt  = idx_q + 2'd1;

    // Refresh prescaler: one tick every REFRESH_DIV cycles
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Select the numeral nibble for the slot about to be shown
    always_comb begin
        nib = disp_q[3:0];
        unique case (idx_nxt)
            2'd0: nib = disp_q[3:0];
            2'd1: nib = disp_q[7:4];
            2'd2: nib = disp_q[11:8];
            2'd3: nib = disp_q[15:12];
            default: nib = disp_q[3:0];
        endcase
    end

    // Digit code and anode pattern for the next slot
    always_comb begin
        digit_nxt = 8'hFF;
        anode_nxt = ~(4'b0001 << idx_nxt);
        unique case (i_Mode)
            2'b00: begin
                if (!score_ok) begin
                    digit_nxt = 8'hFE;
                end else begin
                    digit_nxt = {4'h0, nib};
`ifdef LEADING_ZERO_BLANK_EN
                    if ((idx_nxt == 2'd3 && disp_q[15:12] == 4'h0) ||
                        (idx_nxt == 2'd2 && disp_q[15:8] == 8'h00) ||
                        (idx_nxt == 2'd1 && disp_q[15:4] == 12'h000)) begin
                        digit_nxt = 8'hFF;
                    end
`else
                    digit_nxt = {4'h0, nib};
`endif
                end
            end
            2'b01: begin
                unique case (idx_nxt)
                    2'd3: digit_nxt = 8'h11;
                    2'd2: digit_nxt = 8'h00;
                    2'd1: digit_nxt = 8'h0A;
                    2'd0: digit_nxt = 8'h0E;
                    default: digit_nxt = 8'hFF;
                endcase
            end
            2'b10: digit_nxt = 8'hFF;
            2'b11: digit_nxt = 8'hFE;
            default: digit_nxt = 8'hFF;
        endcase
    end

    // Scan registers: slot index, anode and digit all update on the tick
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            idx_q   <= 2'd0;
            anode_q <= 4'b1111;
            digit_q <= 8'hFF;
        end else if (tick) begin
            idx_q   <= idx_nxt;
            anode_q <= anode_nxt;
            digit_q <= digit_nxt;
        end
    end

    // Double-dabble correction: add 3 to every nibble of 5 or more
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Converter next state: latch a new score, shift 14 times, publish
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        disp_d  = disp_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        iter_d  = iter_q;
        unique case (state_q)
            IDLE: begin
                if (score_ok && i_Score != lat_q) begin
                    lat_d   = i_Score;
                    bcd_d   = '0;
                    bin_d   = i_Score;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_d  = bcd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Converter state registers
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            lat_q   <= '0;
            disp_q  <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            disp_q  <= disp_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            iter_q  <= iter_d;
        end
    end

    assign o_Busy  = (state_q != IDLE);
    assign o_Digit = digit_q;
    assign o_Anode = anode_q;

endmodule

// File: tb/tb_score_digit_scanner.sv
// Randomized bench for score_digit_scanner against a decimal reference model.
// Runs with REFRESH_DIV=4; honours LEADING_ZERO_BLANK_EN like the design.
module tb_score_digit_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] score;
    logic [1:0]  mode;
    logic [7:0]  o_Digit;
    logic [3:0]  o_Anode;
    logic        o_Busy;

    int n_chk = 0;
    int n_err = 0;
    int e     = 0;
    int disp_m = 0;
    int lat_m  = 0;

    score_digit_scanner #(.REFRESH_DIV(4), .CNT_W(17)) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Score(score),
        .i_Mode(mode),
        .o_Digit(o_Digit),
        .o_Anode(o_Anode),
        .o_Busy(o_Busy)
    );

    always #5 clk = ~clk;

    // Edges since reset release; a tick lands on every 4th edge
    always @(posedge clk or posedge rst) begin
        if (rst) e <= 0;
        else e <= e + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_dig(input int s);
        int p = 1;
        for (int i = 0; i < s; i++) p = p * 10;
        case (mode)
            2'b00: begin
                if (score > 9999) return 8'hFE;
`ifdef LEADING_ZERO_BLANK_EN
                if (s > 0 && disp_m < p) return 8'hFF;
`endif
                return 8'((disp_m / p) % 10);
            end
            2'b01: begin
                case (s)
                    3: return 8'h11;
                    2: return 8'h00;
                    1: return 8'h0A;
                    default: return 8'h0E;
                endcase
            end
            2'b10: return 8'hFF;
            default: return 8'hFE;
        endcase
    endfunction

    // If the last edge was a tick, check the slot shown now
    task automatic tick_check(input string tag, output bit hit);
        int s;
        logic [3:0] an;
        hit = 0;
        if (e > 0 && e % 4 == 0) begin
            s  = (e / 4) % 4;
            an = ~(4'b0001 << s);
            check({tag, "_anode"}, 32'(o_Anode), 32'(an));
            check({tag, "_digit"}, 32'(o_Digit), 32'(exp_dig(s)));
            hit = 1;
        end
    endtask

    task automatic scan_check(input string tag);
        int got = 0;
        bit hit;
        for (int k = 0; k < 24 && got < 4; k++) begin
            @(negedge clk);
            tick_check(tag, hit);
            if (hit) got++;
        end
        check({tag, "_ticks"}, 32'(got), 32'd4);
    endtask

    task automatic measure_busy(output int n);
        bit seen = 0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_Busy) begin
                n++;
                seen = 1;
            end else if (seen || k >= 20) begin
                break;
            end
        end
    endtask

    // Apply new inputs and check the conversion pulse and next scan
    task automatic apply(input string tag, input logic [13:0] sc,
                         input logic [1:0] md);
        int  n;
        bit  conv;
        score = sc;
        mode  = md;
        conv  = (int'(sc) <= 9999) && (int'(sc) != lat_m);
        measure_busy(n);
        check({tag, "_busy"}, 32'(n), conv ? 32'd15 : 32'd0);
        if (conv) begin
            lat_m  = int'(sc);
            disp_m = int'(sc);
        end
        scan_check(tag);
    endtask

    task automatic do_reset(input string tag);
        logic [3:0] an1;
        rst = 1'b1;
        #1;
        check({tag, "_rst_anode"}, 32'(o_Anode), 32'hF);
        check({tag, "_rst_digit"}, 32'(o_Digit), 32'hFF);
        check({tag, "_rst_busy"}, 32'(o_Busy), 32'd0);
        score  = '0;
        mode   = 2'b00;
        lat_m  = 0;
        disp_m = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_pre_tick"}, 32'(o_Anode), 32'hF);
        @(negedge clk);
        an1 = 4'b1101;
        check({tag, "_first_tick"}, 32'(o_Anode), 32'(an1));
        check({tag, "_first_digit"}, 32'(o_Digit), 32'(exp_dig(1)));
    endtask

    initial begin
        int n, n2, r;
        bit hit, seen;
        logic [13:0] sc;
        logic [1:0]  md;

        rst   = 1'b0;
        score = '0;
        mode  = 2'b00;
        #2;
        do_reset("init");

        apply("s1234", 14'd1234, 2'b00);
        apply("s7", 14'd7, 2'b00);
        apply("s10000", 14'd10000, 2'b00);
        apply("s9999", 14'd9999, 2'b00);
        apply("lose", 14'd9999, 2'b01);
        apply("blank", 14'd9999, 2'b10);
        apply("dash", 14'd9999, 2'b11);
        apply("back", 14'd9999, 2'b00);

        // Score changes mid-conversion: first run finishes, then restarts
        score = 14'd1234;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_Busy) n++;
        end
        score = 14'd56;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (o_Busy) n++;
            else break;
        end
        check("mid_first_busy", 32'(n), 32'd15);
        disp_m = 1234;
        lat_m  = 1234;
        n2 = 0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k < 12) tick_check("mid_hold", hit);
            if (o_Busy) begin
                n2++;
                seen = 1;
            end else if (seen || k >= 20) begin
                break;
            end
        end
        check("mid_second_busy", 32'(n2), 32'd15);
        disp_m = 56;
        lat_m  = 56;
        scan_check("mid_56");

        // Reset while converting and mid-scan
        score = 14'd4321;
        repeat (6) @(negedge clk);
        check("pre_rst_busy", 32'(o_Busy), 32'd1);
        do_reset("midrst");

        for (int it = 0; it < 16; it++) begin
            r = $urandom_range(0, 5);
            md = (r < 3) ? 2'b00 : 2'(r - 2);
            case ($urandom_range(0, 3))
                0: sc = 14'($urandom_range(0, 99));
                1: sc = 14'($urandom_range(0, 9999));
                2: sc = 14'($urandom_range(10000, 16383));
                default: sc = score;
            endcase
            apply($sformatf("rnd%0d", it), sc, md);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
